// File: rtl/aes_pkg.sv
// Shared AES helpers for the encipher and decipher datapaths.
// Covers byte tables, GF(2^8) arithmetic, the key schedule step and the FSM encoding.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } aes_fsm_e;

  localparam logic [3:0] LAST_ROUND = 4'd14;

  // Forward S-box. Row n of the table holds the entries for inputs n*16 .. n*16+15.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] mul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] rc;
    case (idx)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // State byte s[r,c] sits at bits 127-8*(4c+r) downwards: column-major, s[0,0] in the MSB.
  function automatic int byte_pos(input int r, input int c);
    return 127 - 8*(4*c + r);
  endfunction

  function automatic logic [7:0] state_byte(input logic [127:0] s, input int r, input int c);
    return s[byte_pos(r, c) -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // One column of MixColumns; the row-0 byte is in the word's MSB.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {mul2(a0) ^ mul3(a1) ^ a2 ^ a3,
            a0 ^ mul2(a1) ^ mul3(a2) ^ a3,
            a0 ^ a1 ^ mul2(a2) ^ mul3(a3),
            mul3(a0) ^ a1 ^ a2 ^ mul2(a3)};
  endfunction

  // Advances an 8-word AES-256 schedule window by eight words.
  function automatic logic [255:0] key_step(input logic [255:0] k, input logic [7:0] rc);
    logic [31:0] w [8];
    logic [31:0] n [8];
    for (int i = 0; i < 8; i++) w[i] = k[255 - 32*i -: 32];
    n[0] = w[0] ^ sub_word({w[7][23:0], w[7][31:24]}) ^ {rc, 24'h000000};
    n[1] = w[1] ^ n[0];
    n[2] = w[2] ^ n[1];
    n[3] = w[3] ^ n[2];
    n[4] = w[4] ^ sub_word(n[3]);
    n[5] = w[5] ^ n[4];
    n[6] = w[6] ^ n[5];
    n[7] = w[7] ^ n[6];
    return {n[0], n[1], n[2], n[3], n[4], n[5], n[6], n[7]};
  endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows, MixColumns, AddRoundKey.
// The final round skips MixColumns.
module aes_enc_round
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] round_key_i,
  input  logic         last_round_i,
  output logic [127:0] state_o
);

  logic [31:0] col;

  always_comb begin
    state_o = '0;
    col     = '0;
    for (int c = 0; c < 4; c++) begin
      // ShiftRows folded into the gather: row r of column c comes from column (c+r) mod 4.
      for (int r = 0; r < 4; r++) begin
        col[31 - 8*r -: 8] = sbox(state_byte(state_i, r, (c + r) % 4));
      end
      if (!last_round_i) col = mix_column(col);
      state_o[127 - 32*c -: 32] = col ^ round_key_i[127 - 32*c -: 32];
    end
  end

endmodule

// File: rtl/aes256_encipher_iter.sv
// Iterative AES-256 encryption engine: one round per clock with on-the-fly key expansion,
// wrapped in a valid/ready handshake on both sides.
module aes256_encipher_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] din,
  input  logic [255:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] dout,
  output logic         busy
);

  aes_fsm_e     fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] dout_q, dout_d;
  logic [255:0] key_q, key_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [3:0]   rcon_idx_q, rcon_idx_d;
  logic         in_ready_q, in_ready_d;

  logic [127:0] round_key;
  logic [127:0] round_out;
  logic         last_round;

  // Odd rounds consume the lower half of the window, even rounds the upper half.
  assign round_key  = rnd_q[0] ? key_q[127:0] : key_q[255:128];
  assign last_round = (rnd_q == LAST_ROUND);

  aes_enc_round u_round (
    .state_i      (state_q),
    .round_key_i  (round_key),
    .last_round_i (last_round),
    .state_o      (round_out)
  );

  // NOTE: every _d starts from its _q value so no branch can leave a signal unassigned.
  always_comb begin
    fsm_d      = fsm_q;
    state_d    = state_q;
    dout_d     = dout_q;
    key_d      = key_q;
    rnd_d      = rnd_q;
    rcon_idx_d = rcon_idx_q;

    case (fsm_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d    = din ^ key[255:128];
          key_d      = key;
          rnd_d      = 4'd1;
          rcon_idx_d = 4'd1;
          fsm_d      = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = round_out;
        // Both round keys of the window are spent once an odd round completes.
        if (rnd_q[0]) begin
          key_d      = key_step(key_q, rcon(rcon_idx_q));
          rcon_idx_d = rcon_idx_q + 4'd1;
        end
        if (last_round) begin
          dout_d = round_out;
          fsm_d  = ST_DONE;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      ST_DONE: begin
        if (out_ready) fsm_d = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase

    // Registered so in_ready stays low for as long as reset is held.
    in_ready_d = (fsm_d == ST_IDLE);
  end

  // NOTE: non-blocking assignments so every flop samples the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q      <= ST_IDLE;
      state_q    <= '0;
      dout_q     <= '0;
      key_q      <= '0;
      rnd_q      <= '0;
      rcon_idx_q <= '0;
      in_ready_q <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      state_q    <= state_d;
      dout_q     <= dout_d;
      key_q      <= key_d;
      rnd_q      <= rnd_d;
      rcon_idx_q <= rcon_idx_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (fsm_q == ST_DONE);
  assign busy      = (fsm_q != ST_IDLE);
  assign dout      = dout_q;

endmodule

// File: tb/tb_aes256_encipher_iter.sv
// Self-checking bench for aes256_encipher_iter: known-answer vectors, handshake timing,
// reset behaviour and random blocks against a from-first-principles AES-256 model.
module tb_aes256_encipher_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] din;
  logic [255:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] dout;
  logic         busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0]   sb_tab [256];
  int           acc_cyc [$];
  logic [127:0] out_q [$];

  aes256_encipher_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid && in_ready) acc_cyc.push_back(cyc);
    if (out_valid && out_ready) out_q.push_back(dout);
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map.
  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gf_mul(a[7:0], b[7:0]) == 8'h01) inv = b[7:0];
      sb_tab[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] ref_subw(input logic [31:0] w);
    return {sb_tab[w[31:24]], sb_tab[w[23:16]], sb_tab[w[15:8]], sb_tab[w[7:0]]};
  endfunction

  function automatic logic [127:0] ref_encrypt(input logic [255:0] k, input logic [127:0] pt);
    logic [31:0]  w [60];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc;
    logic [31:0]  tmp;
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] ct;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = k[255 - 32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      tmp = w[i-1];
      if (i % 8 == 0) begin
        tmp = ref_subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h000000};
        rc  = gf_mul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        tmp = ref_subw(tmp);
      end
      w[i] = w[i-8] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
    for (int r = 1; r <= 14; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sb_tab[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) t[4*c + row] = s[4*((c + row) % 4) + row];
      s = t;
      if (r < 14) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03);
          s[4*c+3] = gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31 - 8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) ct[127 - 8*i -: 8] = s[i];
    return ct;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [255:0] rnd256();
    return {rnd128(), rnd128()};
  endfunction

  // Drives one block, scrambles din/key right after acceptance, waits for out_valid and,
  // if out_ready is high, completes the output handshake. Returns observations only.
  task automatic do_block(input logic [255:0] k, input logic [127:0] p,
                          output logic [127:0] ct, output int lat, output bit acc_ok);
    int n;
    n = 0;
    key = k;
    din = p;
    in_valid = 1'b1;
    while (!in_ready && n < 40) begin @(posedge clk); #1; n++; end
    acc_ok = in_ready;
    if (!acc_ok) begin
      in_valid = 1'b0;
      ct = '0;
      lat = -1;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    din = rnd128();
    key = rnd256();
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    ct = dout;
    if (out_ready) begin @(posedge clk); #1; end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; din = '0; key = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++;
    if (dout !== 128'h0) begin bad++; $display("FAIL reset_dout: got %h want 0", dout); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_kat(input string name, input logic [255:0] k, input logic [127:0] p,
                          input logic [127:0] exp);
    logic [127:0] ct;
    int lat;
    bit ok;
    out_ready = 1'b1;
    do_block(k, p, ct, lat, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL %s_accept: in_ready never rose", name); end
    total++;
    if (lat != 14) begin bad++; $display("FAIL %s_latency: got %0d want 14", name, lat); end
    total++;
    if (ct !== exp) begin bad++; $display("FAIL %s_dout: got %h want %h", name, ct, exp); end
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL %s_idle_after: in_ready=%b busy=%b want 1/0", name, in_ready, busy);
    end
  endtask

  task automatic test_backpressure();
    logic [255:0] k;
    logic [127:0] p, exp, ct;
    int lat;
    bit ok;
    k = rnd256(); p = rnd128(); exp = ref_encrypt(k, p);
    out_ready = 1'b0;
    do_block(k, p, ct, lat, ok);
    total++;
    if (!ok || lat != 14 || ct !== exp) begin
      bad++; $display("FAIL bp_first: lat=%0d got %h want %h", lat, ct, exp);
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || dout !== exp || in_ready !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL bp_stall[%0d]: ov=%b rdy=%b busy=%b dout=%h want 1/0/1 %h",
                 i, out_valid, in_ready, busy, dout, exp);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_release: ov=%b rdy=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] ka, kb;
    logic [127:0] pa, pb, ea, eb;
    int n;
    ka = rnd256(); pa = rnd128(); ea = ref_encrypt(ka, pa);
    kb = rnd256(); pb = rnd128(); eb = ref_encrypt(kb, pb);
    acc_cyc.delete();
    out_q.delete();
    out_ready = 1'b1;
    key = ka; din = pa; in_valid = 1'b1;
    n = 0;
    while (acc_cyc.size() < 1 && n < 40) begin @(posedge clk); #1; n++; end
    key = kb; din = pb;
    n = 0;
    while (acc_cyc.size() < 2 && n < 40) begin @(posedge clk); #1; n++; end
    in_valid = 1'b0;
    n = 0;
    while (out_q.size() < 2 && n < 60) begin @(posedge clk); #1; n++; end
    total++;
    if (acc_cyc.size() != 2 || out_q.size() != 2) begin
      bad++;
      $display("FAIL b2b_counts: accepts=%0d outputs=%0d want 2/2", acc_cyc.size(), out_q.size());
    end else begin
      total++;
      if (acc_cyc[1] - acc_cyc[0] != 16) begin
        bad++; $display("FAIL b2b_spacing: got %0d want 16", acc_cyc[1] - acc_cyc[0]);
      end
      total++;
      if (out_q[0] !== ea) begin bad++; $display("FAIL b2b_first: got %h want %h", out_q[0], ea); end
      total++;
      if (out_q[1] !== eb) begin bad++; $display("FAIL b2b_second: got %h want %h", out_q[1], eb); end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [255:0] k;
    logic [127:0] p, exp, ct;
    int n, lat;
    bit ok, seen;
    out_ready = 1'b1;
    key = rnd256(); din = rnd128(); in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      bad++; $display("FAIL rstmid_async: ov=%b busy=%b rdy=%b want 0/0/0", out_valid, busy, in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    total++;
    if (seen) begin bad++; $display("FAIL rstmid_no_output: got out_valid=1 want 0"); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready: got %b want 1", in_ready); end
    k = rnd256(); p = rnd128(); exp = ref_encrypt(k, p);
    do_block(k, p, ct, lat, ok);
    total++;
    if (!ok || lat != 14 || ct !== exp) begin
      bad++; $display("FAIL rstmid_next_block: lat=%0d got %h want %h", lat, ct, exp);
    end
  endtask

  task automatic test_random(input int count);
    logic [255:0] k;
    logic [127:0] p, exp, ct;
    int lat;
    bit ok;
    out_ready = 1'b1;
    for (int i = 0; i < count; i++) begin
      k = rnd256(); p = rnd128(); exp = ref_encrypt(k, p);
      do_block(k, p, ct, lat, ok);
      total++;
      if (!ok || lat != 14 || ct !== exp) begin
        bad++;
        $display("FAIL random[%0d]: lat=%0d got %h want %h (key %h pt %h)", i, lat, ct, exp, k, p);
      end
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_kat("fips_c3",
             256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
             128'h00112233445566778899aabbccddeeff,
             128'h8ea2b7ca516745bfeafc49904b496089);
    test_kat("sp800_38a",
             256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
             128'h6bc1bee22e409f96e93d7e117393172a,
             128'hf3eed1bdb5d2a03c064b5a7e3db181f8);
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_random(1000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes256_encipher_iter.md
# aes256_encipher_iter

Iterative AES-256 encryption engine, one round per clock, with on-the-fly key expansion. It is the forward-direction counterpart of the team's AES-256 decipher datapath and uses the same byte and word ordering, so a block encrypted here decrypts there unchanged. It sits on a valid/ready stream: it accepts one 128-bit plaintext plus a 256-bit key, and returns one 128-bit ciphertext 14 cycles later.

## Interface
- Parameters: none. Round count (14) and key size (256) are fixed.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  din/key are valid.
- in_ready  out  1  engine can accept a block (high only in IDLE).
- din  in  128  plaintext. din[127:120] = state byte s[0,0]; column-major order.
- key  in  256  cipher key. key[255:224] = w0 … key[31:0] = w7.
- out_valid  out  1  dout holds a finished ciphertext.
- out_ready  in  1  downstream accepts dout.
- dout  out  128  ciphertext, same byte order as din.
- busy  out  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on in_valid && in_ready.
  - RUN → DONE after round 14.
  - DONE → IDLE on out_ready.
- On accept:
  - state_q <= din ^ key[255:128] (round key 0).
  - key_q <= key.
  - rnd_q <= 1.
  - rcon index <= 1.
- key_q always holds one 8-word schedule window:
  - Round key 2j = key_q[255:128].
  - Round key 2j+1 = key_q[127:0].
  - Round r uses key_q[127:0] when r is odd, key_q[255:128] when r is even.
- After each odd round, key_q advances by one AES-256 expansion step (8 new words):
  - First word uses RotWord + SubWord + rcon[i].
  - Fifth word uses SubWord only.
  - The rcon index then increments (rcon = 01,02,04,…,40).
- Each RUN cycle applies SubBytes, ShiftRows, MixColumns, AddRoundKey to state_q. Round 14 omits MixColumns.
- key and din are sampled only at accept. Changes afterwards have no effect.
- dout is a register. It updates only on the round-14 edge and holds until the DONE→IDLE handshake.
- rnd_q is 4 bits, range 1..14, and never wraps. Reaching 14 in RUN forces DONE.

## Timing
- Reset values: in_ready=0 while rst_n low, then 1 (IDLE); out_valid=0; busy=0; dout=0; state_q, key_q, rnd_q = 0.
- Accept edge E0. Rounds 1..14 complete on edges E1..E14. out_valid rises after E14, so latency is 14 cycles from acceptance.
- in_ready=0 from E0 until the cycle after the output handshake. The earliest next accept is E16 (16 cycles/block) when out_ready is held high.
- If out_ready is already high when out_valid rises, the handshake completes at E15.
- Stall: out_valid and dout stay stable while out_ready=0, for any length.
- in_valid during RUN/DONE is ignored and not buffered.
- rst_n low at any point (mid-round or in DONE) returns to IDLE asynchronously. The partial result is discarded, out_valid drops immediately, and no output appears after release.

## Structure
- Shared package aes_pkg, also usable by the decipher side, holds:
  - sbox function (256-entry), xtime, mul2/mul3.
  - rcon table.
  - FSM state enum.
  - Byte-index helpers for column-major state.
- Sub-module aes_enc_round (combinational): inputs state, round key, last_round flag; output next state.
- Key-step logic stays inline in the top or as a package function. The top contains the FSM, registers and handshake.

## Test plan
- FIPS-197 C.3: key 000102…1e1f, din 00112233445566778899aabbccddeeff → dout 8ea2b7ca516745bfeafc49904b496089, out_valid exactly 14 cycles after accept.
- SP800-38A ECB-AES256: key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, din 6bc1bee22e409f96e93d7e117393172a → f3eed1bdb5d2a03c064b5a7e3db181f8.
- Backpressure: hold out_ready=0 for 20 cycles → dout/out_valid stable and in_ready=0 throughout. Pulse out_ready → IDLE next cycle.
- Back-to-back with out_ready=1 and in_valid held, two blocks → accepts 16 cycles apart, both ciphertexts correct. din/key changed mid-RUN → no effect on the result.
- Assert rst_n low at round 7 for 1 cycle → out_valid stays 0, in_ready=1 after release. The next block encrypts correctly.
- Round trip: 1000 random key/plaintext pairs through this block, then the decipher block → plaintext recovered bit-exact.
